mips_fetch_queue: RTL and testbench
===================================

# mips_fetch_queue

Parametrised instruction fetch queue between the IF and ID stages of the 5-stage MIPS pipeline. It absorbs I-cache stall jitter, carries each fetched instruction's PC+4 and branch-prediction bit to ID, and empties the queue in one cycle on a pipeline redirect. It replaces the direct IF-to-ID wiring in `mips_core`. It adds a valid/ready handshake, configurable depth and a flush path.

## Interface
Parameters:
- `DEPTH`, 4: number of entries; a power of two, 2 to 64.
- `INST_WIDTH`, `MIPS_INST_WIDTH`: instruction word width.
- `ADDR_WIDTH`, `MIPS_ADDR_WIDTH`: PC+4 width.
- `RFIDX_WIDTH`, `MIPS_RFIDX_WIDTH`: register index width.

Ports:
- `clk`  in  1: the single clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `flush`  in  1: redirect from EX; discards all queued entries.
- `in_valid`  in  1: IF presents an entry.
- `in_ready`  out  1: the queue accepts the entry this cycle.
- `in_inst`  in  INST_WIDTH: fetched instruction.
- `in_pc_incr`  in  ADDR_WIDTH: PC+4 of that instruction.
- `in_prdt_taken`  in  1: predictor said taken.
- `out_valid`  out  1: an entry is presented to ID.
- `out_ready`  in  1: ID consumes the entry this cycle.
- `out_inst`  out  INST_WIDTH: head instruction.
- `out_pc_incr`  out  ADDR_WIDTH: head PC+4.
- `out_prdt_taken`  out  1: head prediction bit.
- `out_rs_idx`  out  RFIDX_WIDTH: `out_inst[25:21]`.
- `out_rt_idx`  out  RFIDX_WIDTH: `out_inst[20:16]`.
- `count`  out  clog2(DEPTH)+1: current occupancy.

## Operation
- Storage is a circular buffer with a write pointer, a read pointer and an occupancy counter.
  - Each pointer is clog2(DEPTH) bits and wraps naturally from DEPTH-1 to 0.
  - The counter runs from 0 to DEPTH.
- An enqueue happens on `in_valid && in_ready`: the entry is written at the write pointer and the write pointer increments.
- A dequeue happens on `out_valid && out_ready`: the read pointer increments.
- Counter update:
  - Enqueue only: count+1.
  - Dequeue only: count-1.
  - Both in the same cycle: count is unchanged. This holds at any occupancy, including count == 1.
- `in_ready = (count != DEPTH)`. There is no enqueue-through-full: a full queue refuses input even when a dequeue happens in the same cycle.
- `out_valid = (count != 0)`, except where the bypass configuration applies.
- `out_*` are driven by the entry at the read pointer. `out_rs_idx` and `out_rt_idx` are combinational slices of `out_inst`.
- Flush:
  - At the next edge both pointers and `count` return to 0.
  - An enqueue handshake in the flush cycle completes but its entry is discarded.
  - A dequeue handshake in the flush cycle completes. ID is flushed by the same signal.
  - `flush` does not combinationally gate `in_ready` or `out_valid`.
- Reset behaves like flush and has priority over it. Reset in the middle of a burst loses all entries.
- After reset:
  - `count` = 0, `out_valid` = 0, `in_ready` = 1.
  - Storage contents are don't-care; `out_*` data are X-tolerant while `out_valid` = 0.

## Timing
- Without bypass, an enqueued entry is visible at `out_*` in the cycle after its handshake, a latency of 1.
- Sustained throughput is one entry per cycle whenever 0 < count < DEPTH.
- `count` and the pointers are registered. `in_ready` depends only on registered state.
- The first entry after a flush can be enqueued in the cycle following the flush.

## Configuration
- `MIPS_FQ_BYPASS_EN` defined:
  - When count == 0, `out_valid = in_valid` and `out_*` are driven combinationally from `in_*`.
  - If `out_ready` is also high, the entry passes through in the same cycle without being written, and pointers and count are unchanged. This gives zero latency through an empty queue.
  - If `out_ready` is low, the entry is written normally.
  - `out_valid` and `out_*` then depend combinationally on `in_*`.
- `MIPS_FQ_BYPASS_EN` undefined: behaviour is exactly as in Operation; all outputs come from registered state.

## Test plan
- Reset with `DEPTH`=4:
  - Hold `rst` for 2 cycles → `count`=0, `out_valid`=0, `in_ready`=1.
  - Release reset and enqueue 0x8C220004 (pc_incr 0x4) → `out_valid`=1 on the next cycle, `out_rs_idx`=1, `out_rt_idx`=2.
- Fill with `out_ready`=0:
  - Enqueue 4 entries → `count`=4, `in_ready`=0.
  - A fifth `in_valid` is not accepted.
  - Set `out_ready`=1 → entries come out in FIFO order.
- Wrap-around:
  - Stream 10 entries with `in_valid`=`out_ready`=1 continuously → data order is preserved across the pointer wrap.
  - `count` stays at 1 after the first entry.
- Flush with `count`=3 and a simultaneous enqueue → next cycle `count`=0 and `out_valid`=0; the flushed entry never appears.
- Reset in the middle of a stream with `count`=2 → next cycle `count`=0. A following enqueue comes out first.
- With `MIPS_FQ_BYPASS_EN`:
  - Empty queue with `in_valid`=`out_ready`=1 and `in_inst`=0x00000020 → `out_valid`=1 and `out_inst`=0x00000020 in the same cycle; `count` stays 0.
  - Without the macro, the same stimulus gives `out_valid`=0 that cycle.

Source files
------------

// File: rtl/mips_fetch_queue.sv
// -----------------------------------------------------------------------------
// mips_fetch_queue
//
// Instruction fetch queue between the IF and ID stages of the 5-stage MIPS
// pipeline. It absorbs I-cache stall jitter and carries each fetched
// instruction, its PC+4 and its branch-prediction bit to ID. A redirect from
// EX (flush) empties the queue in one cycle.
//
// Handshake semantics (both sides): a transfer happens on a rising edge where
// valid && ready are both high. The producer holds valid and its payload
// stable until that edge. The consumer may raise or drop ready in any cycle.
// in_ready depends only on registered state. Without bypass, out_valid
// depends only on registered state too.
//
// Optional feature macro: MIPS_FQ_BYPASS_EN
//   When defined, an empty queue forwards in_* straight to out_* in the same
//   cycle. If ID also takes the entry that cycle, the entry is never written
//   into the queue.
//
// Parameters:
//   DEPTH        number of entries (power of two, 2..64)
//   INST_WIDTH   instruction word width
//   ADDR_WIDTH   PC+4 width
//   RFIDX_WIDTH  register index width
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   flush             redirect from EX, discards every queued entry
//   in_valid/in_ready IF side handshake
//   in_inst, in_pc_incr, in_prdt_taken      IF payload
//   out_valid/out_ready ID side handshake
//   out_inst, out_pc_incr, out_prdt_taken   head entry payload
//   out_rs_idx, out_rt_idx                  out_inst[25:21], out_inst[20:16]
//   count             current occupancy (0..DEPTH)
// -----------------------------------------------------------------------------
`ifndef MIPS_INST_WIDTH
`define MIPS_INST_WIDTH 32
`endif
`ifndef MIPS_ADDR_WIDTH
`define MIPS_ADDR_WIDTH 32
`endif
`ifndef MIPS_RFIDX_WIDTH
`define MIPS_RFIDX_WIDTH 5
`endif

module mips_fetch_queue #(
  parameter int DEPTH       = 4,
  parameter int INST_WIDTH  = `MIPS_INST_WIDTH,
  parameter int ADDR_WIDTH  = `MIPS_ADDR_WIDTH,
  parameter int RFIDX_WIDTH = `MIPS_RFIDX_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [INST_WIDTH-1:0]    in_inst,
  input  logic [ADDR_WIDTH-1:0]    in_pc_incr,
  input  logic                     in_prdt_taken,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [INST_WIDTH-1:0]    out_inst,
  output logic [ADDR_WIDTH-1:0]    out_pc_incr,
  output logic                     out_prdt_taken,
  output logic [RFIDX_WIDTH-1:0]   out_rs_idx,
  output logic [RFIDX_WIDTH-1:0]   out_rt_idx,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // Storage is not reset: its contents are only observed while count != 0.
  logic [INST_WIDTH-1:0] inst_mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] pc_mem_q   [DEPTH];
  logic                  prdt_mem_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;

  logic empty;
  logic pass_through;
  logic enq;
  logic deq;

  always_comb begin
    empty    = (count_q == '0);
    in_ready = (count_q != FULL_CNT);
`ifdef MIPS_FQ_BYPASS_EN
    // An empty queue presents the incoming entry directly. If ID takes it in
    // the same cycle it never touches the storage.
    pass_through   = empty && in_valid && out_ready;
    out_valid      = empty ? in_valid      : 1'b1;
    out_inst       = empty ? in_inst       : inst_mem_q[rd_ptr_q];
    out_pc_incr    = empty ? in_pc_incr    : pc_mem_q[rd_ptr_q];
    out_prdt_taken = empty ? in_prdt_taken : prdt_mem_q[rd_ptr_q];
`else
    pass_through   = 1'b0;
    out_valid      = !empty;
    out_inst       = inst_mem_q[rd_ptr_q];
    out_pc_incr    = pc_mem_q[rd_ptr_q];
    out_prdt_taken = prdt_mem_q[rd_ptr_q];
`endif
    // A full queue refuses input even if the head leaves this cycle.
    enq = in_valid && in_ready && !pass_through;
    // A dequeue only moves the read pointer when the head came from storage.
    deq = out_valid && out_ready && !empty;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      // Handshakes in the flush cycle complete, but their effect is dropped.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (deq) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({enq, deq})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      inst_mem_q[wr_ptr_q] <= in_inst;
      pc_mem_q[wr_ptr_q]   <= in_pc_incr;
      prdt_mem_q[wr_ptr_q] <= in_prdt_taken;
    end
  end

  assign out_rs_idx = RFIDX_WIDTH'(out_inst[25:21]);
  assign out_rt_idx = RFIDX_WIDTH'(out_inst[20:16]);
  assign count      = count_q;

endmodule

// File: tb/tb_mips_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_mips_fetch_queue
//
// Bench for mips_fetch_queue with DEPTH = 4. Each cycle the inputs change just
// after the rising edge. The outputs are sampled on the falling edge and
// compared against a reference occupancy model and a queue of expected
// {inst, pc_incr, prdt} payloads. A table of single-cycle records covers reset,
// the first enqueue, fill-to-full and drain. Hand-written sequences then cover
// the pointer wrap, flush, mid-stream reset and the empty-queue bypass case.
// A random phase follows.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_mips_fetch_queue;

  localparam int DEPTH = 4;
  localparam int PW    = 32 + 32 + 1;
`ifdef MIPS_FQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    logic        rst;
    logic        flush;
    logic        iv;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        pt;
    logic        ordy;
    int          exp_count;
    logic        exp_ir;
    logic        exp_ov;
  } vec_t;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, in_prdt_taken;
  logic [31:0] in_inst, in_pc_incr;
  logic        out_valid, out_ready, out_prdt_taken;
  logic [31:0] out_inst, out_pc_incr;
  logic [4:0]  out_rs_idx, out_rt_idx;
  logic [2:0]  count;

  always #5 clk = ~clk;

  mips_fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc_incr(in_pc_incr), .in_prdt_taken(in_prdt_taken),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_pc_incr(out_pc_incr),
    .out_prdt_taken(out_prdt_taken),
    .out_rs_idx(out_rs_idx), .out_rt_idx(out_rt_idx),
    .count(count)
  );

  // ---------------- scoreboard ----------------
  logic [PW-1:0] exp_q[$];
  int            model_count = 0;
  int            n_checks    = 0;
  int            n_errors    = 0;

  task automatic check(input string name, input logic [PW-1:0] act,
                       input logic [PW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_payload(input string name, input logic [PW-1:0] exp);
    logic [31:0] e_inst;
    e_inst = exp[PW-1 -: 32];
    check({name, ".inst"}, PW'(out_inst), PW'(e_inst));
    check({name, ".pc"},   PW'(out_pc_incr), PW'(exp[32:1]));
    check({name, ".prdt"}, PW'(out_prdt_taken), PW'(exp[0]));
    check({name, ".rs"},   PW'(out_rs_idx), PW'(e_inst[25:21]));
    check({name, ".rt"},   PW'(out_rt_idx), PW'(e_inst[20:16]));
  endtask

  function automatic vec_t mk(input logic r, input logic f, input logic iv,
                              input logic [31:0] inst, input logic [31:0] pc,
                              input logic pt, input logic ordy, input int ec,
                              input logic eir, input logic eov);
    vec_t v;
    v.rst = r; v.flush = f; v.iv = iv; v.inst = inst; v.pc = pc; v.pt = pt;
    v.ordy = ordy; v.exp_count = ec; v.exp_ir = eir; v.exp_ov = eov;
    return v;
  endfunction

  // ---------------- driver: one cycle ----------------
  task automatic step(input vec_t v, input bit tab, input string tag);
    bit bypass_now, enq, deq;
    rst = v.rst; flush = v.flush; in_valid = v.iv; in_inst = v.inst;
    in_pc_incr = v.pc; in_prdt_taken = v.pt; out_ready = v.ordy;

    bypass_now = BYP && (model_count == 0) && v.iv;
    enq = v.iv && (model_count != DEPTH) && !(bypass_now && v.ordy);
    deq = (model_count != 0) && v.ordy;

    @(negedge clk);
    check({tag, ".count"},     PW'(count),     PW'(model_count));
    check({tag, ".in_ready"},  PW'(in_ready),  PW'(model_count != DEPTH));
    check({tag, ".out_valid"}, PW'(out_valid), PW'((model_count != 0) || bypass_now));
    if (tab) begin
      check({tag, ".tab_count"}, PW'(count),     PW'(v.exp_count));
      check({tag, ".tab_ir"},    PW'(in_ready),  PW'(v.exp_ir));
      check({tag, ".tab_ov"},    PW'(out_valid), PW'(v.exp_ov));
    end
    if (model_count != 0 && exp_q.size() > 0) check_payload({tag, ".head"}, exp_q[0]);
    else if (bypass_now) check_payload({tag, ".byp"}, {v.inst, v.pc, v.pt});

    @(posedge clk);
    #1;
    if (v.rst || v.flush) begin
      model_count = 0;
      exp_q.delete();
    end else begin
      if (deq) void'(exp_q.pop_front());
      if (enq) exp_q.push_back({v.inst, v.pc, v.pt});
      model_count = model_count + (enq ? 1 : 0) - (deq ? 1 : 0);
    end
  endtask

  task automatic put(input logic [31:0] inst, input logic ordy, input string tag);
    step(mk(0, 0, 1, inst, inst + 32'h4, inst[0], ordy, 0, 0, 0), 0, tag);
  endtask

  task automatic idle(input logic ordy, input string tag);
    step(mk(0, 0, 0, 32'h0, 32'h0, 0, ordy, 0, 0, 0), 0, tag);
  endtask

  // ---------------- stimulus ----------------
  vec_t vecs[12];

  initial begin
    // Reset and first enqueue, fill to full, refused fifth entry, FIFO drain.
    vecs[0]  = mk(0, 0, 0, 32'h0,        32'h0,  0, 0, 0, 1, 0);
    vecs[1]  = mk(0, 0, 1, 32'h8C220004, 32'h4,  0, 0, 0, 1, BYP);
    vecs[2]  = mk(0, 0, 0, 32'h0,        32'h0,  0, 0, 1, 1, 1);
    vecs[3]  = mk(0, 0, 1, 32'h00A41820, 32'h8,  1, 0, 1, 1, 1);
    vecs[4]  = mk(0, 0, 1, 32'h10C7FFFE, 32'hC,  0, 0, 2, 1, 1);
    vecs[5]  = mk(0, 0, 1, 32'hAD090010, 32'h10, 1, 0, 3, 1, 1);
    vecs[6]  = mk(0, 0, 1, 32'hDEADBEEF, 32'h14, 0, 0, 4, 0, 1);
    vecs[7]  = mk(0, 0, 1, 32'hDEADBEEF, 32'h14, 0, 1, 4, 0, 1);
    vecs[8]  = mk(0, 0, 0, 32'h0,        32'h0,  0, 1, 3, 1, 1);
    vecs[9]  = mk(0, 0, 0, 32'h0,        32'h0,  0, 1, 2, 1, 1);
    vecs[10] = mk(0, 0, 0, 32'h0,        32'h0,  0, 1, 1, 1, 1);
    vecs[11] = mk(0, 0, 0, 32'h0,        32'h0,  0, 0, 0, 1, 0);

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc_incr = '0;
    in_prdt_taken = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 12; i++) step(vecs[i], 1, $sformatf("vec%0d", i));

    // Explicit decode of the first table entry's register indices.
    check("rs_const", PW'(32'h8C220004 >> 21 & 32'h1F), PW'(32'd1));

    // Wrap-around: 10 back-to-back entries with ID always ready.
    for (int i = 0; i < 10; i++) begin
      put(32'h1000_0000 + i * 32'h0001_0101, 1'b1, $sformatf("wrap%0d", i));
      if (i > 0) check("wrap_count", PW'(count), PW'(BYP ? 0 : 1));
    end
    idle(1'b1, "wrap_drain");
    idle(1'b0, "wrap_empty");

    // Flush with three entries queued and an enqueue in the flush cycle.
    put(32'h2001_0001, 1'b0, "fl_a");
    put(32'h2002_0002, 1'b0, "fl_b");
    put(32'h2003_0003, 1'b0, "fl_c");
    step(mk(0, 1, 1, 32'hBAD0BAD0, 32'h44, 1, 0, 0, 0, 0), 0, "fl_cyc");
    idle(1'b0, "fl_after");
    check("flush_count", PW'(count), PW'(0));
    put(32'h2004_0004, 1'b0, "fl_new");
    idle(1'b1, "fl_pop");
    idle(1'b0, "fl_done");

    // Reset in the middle of a stream with two entries queued.
    put(32'h3001_0001, 1'b0, "rs_a");
    put(32'h3002_0002, 1'b0, "rs_b");
    step(mk(1, 0, 1, 32'h3BAD_0000, 32'h88, 0, 1, 0, 0, 0), 0, "rs_cyc");
    idle(1'b0, "rs_after");
    put(32'h3003_0003, 1'b0, "rs_new");
    idle(1'b1, "rs_pop");
    idle(1'b0, "rs_done");

    // Empty queue with both sides active: zero latency only with bypass.
    in_valid = 1'b1; in_inst = 32'h00000020; in_pc_incr = 32'h100;
    in_prdt_taken = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("byp_out_valid", PW'(out_valid), PW'(BYP));
    if (BYP) check("byp_out_inst", PW'(out_inst), PW'(32'h00000020));
    @(posedge clk);
    #1;
    if (!BYP) begin
      exp_q.push_back({32'h00000020, 32'h100, 1'b0});
      model_count = 1;
    end
    idle(1'b1, "byp_next");
    idle(1'b0, "byp_done");

    // Random phase: jittery producer/consumer with occasional flushes.
    for (int i = 0; i < 300; i++) begin
      logic [31:0] r;
      r = $urandom;
      step(mk(0, ($urandom_range(0, 29) == 0), ($urandom_range(0, 3) != 0), r,
              r ^ 32'h5555_0000, r[3], ($urandom_range(0, 2) != 0), 0, 0, 0),
           0, $sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
